// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one downstream sram-like memory port between the instruction-fetch
//   requester and the data (MEM/EXE) requester. Data has priority while the
//   arbiter is unlocked. A request that is presented but not accepted locks
//   the grant until mem_addr_ok. A small in-order ID FIFO records who issued
//   each accepted request, so that mem_data_ok/mem_rdata are routed back to
//   the right requester.
//
// Ports
//   clk, reset                 : clock and synchronous active-high reset
//   inst_req/inst_addr         : fetch request (read, word size)
//   inst_addr_ok/inst_data_ok  : fetch accept / fetch response strobes
//   inst_rdata                 : fetch read data (mem_rdata pass-through)
//   data_req/wr/size/addr/wdata: data request fields
//   data_addr_ok/data_data_ok  : data accept / data response strobes
//   data_rdata                 : load data (mem_rdata pass-through)
//   mem_req/wr/size/addr/wdata : downstream request fields
//   mem_addr_ok/mem_data_ok    : downstream accept / response strobes
//   mem_rdata                  : downstream read data
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic [CW-1:0]              count_r;
  logic [PW-1:0]              rd_ptr_r;
  logic [PW-1:0]              wr_ptr_r;
  logic [MAX_OUTSTANDING-1:0] id_fifo_r;   // 0 = inst, 1 = data
  logic                       lock_r;
  logic                       lock_sel_r;  // 1 = data holds the lock

  logic sel_data_s;
  logic full_s;
  logic req_s;
  logic handshake_s;
  logic pop_s;
  logic head_s;

  // Grant selection, acceptance and response routing.
  always_comb begin
    sel_data_s  = lock_r ? lock_sel_r : data_req;
    full_s      = (count_r == CW'(MAX_OUTSTANDING));
    // No bypass: a full FIFO blocks requests even when a pop happens this cycle.
    req_s       = !reset && !full_s && (inst_req || data_req);
    handshake_s = req_s && mem_addr_ok;
    // A response with nothing outstanding is a protocol error and is dropped.
    pop_s       = !reset && mem_data_ok && (count_r != '0);
    head_s      = id_fifo_r[rd_ptr_r];

    mem_req      = req_s;
    mem_wr       = sel_data_s ? data_wr    : 1'b0;
    mem_size     = sel_data_s ? data_size  : 2'b10;
    mem_addr     = sel_data_s ? data_addr  : inst_addr;
    mem_wdata    = sel_data_s ? data_wdata : 32'h0000_0000;

    inst_addr_ok = handshake_s && !sel_data_s;
    data_addr_ok = handshake_s &&  sel_data_s;
    inst_data_ok = pop_s && !head_s;
    data_data_ok = pop_s &&  head_s;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  // ID FIFO, occupancy count and grant lock state.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r    <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      id_fifo_r  <= '0;
      lock_r     <= 1'b0;
      lock_sel_r <= 1'b0;
    end else begin
      if (handshake_s) begin
        id_fifo_r[wr_ptr_r] <= sel_data_s;
        wr_ptr_r            <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end

      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end

      case ({handshake_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase

      // A presented but unaccepted request pins the grant to its requester.
      if (handshake_s) begin
        lock_r <= 1'b0;
      end else if (req_s) begin
        lock_r     <= 1'b1;
        lock_sel_r <= sel_data_s;
      end else begin
        lock_r <= lock_r;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int passed = 0;
  int total  = 0;

  sram_like_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to 1 ns after the next rising edge; inputs are then driven and
  // outputs checked at 2 ns after the edge, well before the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    logic q[$];
    logic ir, dr, push, pop, hd;
    logic [31:0] rd;

    // ---------------- reset: outputs forced low ----------------
    idle();
    reset = 1'b1;
    tick();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    settle();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("rst_inst_data_ok", inst_data_ok, 1'b0);
    chk("rst_data_data_ok", data_data_ok, 1'b0);
    tick();
    reset = 1'b0; idle();
    tick();

    // ---------------- test 1: single fetch ----------------
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    settle();
    chk("t1_c0_mem_req", mem_req, 1'b1);
    chk("t1_c0_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("t1_c0_mem_size", mem_size, 2'd2);
    chk("t1_c0_inst_addr_ok", inst_addr_ok, 1'b0);
    tick();
    mem_addr_ok = 1'b1;
    settle();
    chk("t1_c1_inst_addr_ok", inst_addr_ok, 1'b1);
    chk("t1_c1_data_addr_ok", data_addr_ok, 1'b0);
    tick();
    idle();
    settle();
    chk("t1_c2_mem_req", mem_req, 1'b0);
    chk("t1_c2_inst_data_ok", inst_data_ok, 1'b0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h2408_0001;
    settle();
    chk("t1_c3_inst_data_ok", inst_data_ok, 1'b1);
    chk("t1_c3_inst_rdata", inst_rdata, 32'h2408_0001);
    chk("t1_c3_data_data_ok", data_data_ok, 1'b0);
    tick();
    idle();

    // ---------------- test 2: data wins simultaneous requests ----------------
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
    data_addr = 32'h8000_0013; data_wdata = 32'h0000_00AB;
    mem_addr_ok = 1'b1;
    settle();
    chk("t2_a_data_addr_ok", data_addr_ok, 1'b1);
    chk("t2_a_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("t2_a_mem_wr", mem_wr, 1'b1);
    chk("t2_a_mem_size", mem_size, 2'd0);
    chk("t2_a_mem_addr", mem_addr, 32'h8000_0013);
    chk("t2_a_mem_wdata", mem_wdata, 32'h0000_00AB);
    tick();
    data_req = 1'b0;
    settle();
    chk("t2_b_inst_addr_ok", inst_addr_ok, 1'b1);
    chk("t2_b_mem_wr", mem_wr, 1'b0);
    chk("t2_b_mem_addr", mem_addr, 32'hBFC0_0004);
    chk("t2_b_mem_wdata", mem_wdata, 32'h0);
    tick();
    idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
    settle();
    chk("t2_c_data_data_ok", data_data_ok, 1'b1);
    chk("t2_c_inst_data_ok", inst_data_ok, 1'b0);
    tick();
    mem_rdata = 32'h2222_2222;
    settle();
    chk("t2_d_inst_data_ok", inst_data_ok, 1'b1);
    chk("t2_d_data_data_ok", data_data_ok, 1'b0);
    chk("t2_d_inst_rdata", inst_rdata, 32'h2222_2222);
    tick();
    idle();

    // ---------------- test 3: lock holds the fetch grant ----------------
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    settle();
    chk("t3_c0_mem_addr", mem_addr, 32'hBFC0_0000);
    tick();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1000;
    for (int c = 1; c <= 3; c++) begin
      settle();
      chk("t3_locked_mem_addr", mem_addr, 32'hBFC0_0000);
      chk("t3_locked_data_addr_ok", data_addr_ok, 1'b0);
      tick();
    end
    mem_addr_ok = 1'b1;
    settle();
    chk("t3_c4_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("t3_c4_inst_addr_ok", inst_addr_ok, 1'b1);
    chk("t3_c4_data_addr_ok", data_addr_ok, 1'b0);
    tick();
    inst_req = 1'b0;
    settle();
    chk("t3_c5_data_addr_ok", data_addr_ok, 1'b1);
    chk("t3_c5_mem_addr", mem_addr, 32'h8000_1000);
    tick();
    idle();
    mem_data_ok = 1'b1;
    settle();
    chk("t3_r0_inst_data_ok", inst_data_ok, 1'b1);
    tick();
    settle();
    chk("t3_r1_data_data_ok", data_data_ok, 1'b1);
    tick();
    idle();

    // ---------------- test 4: full blocks, no bypass on pop ----------------
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100; mem_addr_ok = 1'b1;
    settle();
    chk("t4_a_inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    settle();
    chk("t4_b_inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h8000_2000;
    settle();
    chk("t4_full_mem_req", mem_req, 1'b0);
    chk("t4_full_data_addr_ok", data_addr_ok, 1'b0);
    tick();
    mem_data_ok = 1'b1;
    settle();
    chk("t4_n_mem_req", mem_req, 1'b0);
    chk("t4_n_data_addr_ok", data_addr_ok, 1'b0);
    chk("t4_n_inst_data_ok", inst_data_ok, 1'b1);
    tick();
    mem_data_ok = 1'b0;
    settle();
    chk("t4_n1_data_addr_ok", data_addr_ok, 1'b1);
    tick();
    idle();
    mem_data_ok = 1'b1;
    settle();
    chk("t4_d0_inst_data_ok", inst_data_ok, 1'b1);
    tick();
    settle();
    chk("t4_d1_data_data_ok", data_data_ok, 1'b1);
    tick();
    idle();

    // ---------------- test 5: streamed push/pop with random mix ----------------
    for (int i = 0; i <= 20; i++) begin
      ir = 1'b0; dr = 1'b0;
      if (i < 20) begin
        dr = 1'($urandom_range(0, 1));
        ir = !dr || 1'($urandom_range(0, 1));
      end
      push = ir || dr;
      pop  = (q.size() > 0);
      hd   = pop ? q[0] : 1'b0;
      rd   = $urandom;
      inst_req = ir; inst_addr = 32'hBFC0_1000 + 32'(i * 4);
      data_req = dr; data_wr = 1'($urandom_range(0, 1)); data_size = 2'd2;
      data_addr = 32'h8000_3000 + 32'(i * 4);
      mem_addr_ok = 1'b1; mem_data_ok = pop; mem_rdata = rd;
      settle();
      chk("t5_inst_addr_ok", inst_addr_ok, push && !dr);
      chk("t5_data_addr_ok", data_addr_ok, push && dr);
      chk("t5_inst_data_ok", inst_data_ok, pop && !hd);
      chk("t5_data_data_ok", data_data_ok, pop && hd);
      if (pop) chk("t5_rdata", hd ? data_rdata : inst_rdata, rd);
      tick();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(dr);
    end
    idle();
    // Queue must be empty now: a stray response is dropped.
    chk("t5_model_empty", 32'(q.size()), 32'd0);
    mem_data_ok = 1'b1;
    settle();
    chk("t5_end_inst_data_ok", inst_data_ok, 1'b0);
    chk("t5_end_data_data_ok", data_data_ok, 1'b0);
    tick();
    idle();

    // ---------------- test 6: reset with transactions in flight ----------------
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200; mem_addr_ok = 1'b1;
    settle();
    chk("t6_a_inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h8000_4000;
    settle();
    chk("t6_b_data_addr_ok", data_addr_ok, 1'b1);
    tick();
    idle();
    reset = 1'b1;
    settle();
    chk("t6_rst_mem_req", mem_req, 1'b0);
    tick();
    reset = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t6_stray_inst_data_ok", inst_data_ok, 1'b0);
    chk("t6_stray_data_data_ok", data_data_ok, 1'b0);
    tick();
    idle();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0300; mem_addr_ok = 1'b1;
    settle();
    chk("t6_new_inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_0000;
    settle();
    chk("t6_new_inst_data_ok", inst_data_ok, 1'b1);
    chk("t6_new_inst_rdata", inst_rdata, 32'h3C1D_0000);
    chk("t6_new_data_data_ok", data_data_ok, 1'b0);
    tick();
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
